// File: rtl/mem_arb_pkg.sv
// mem_arb_pkg: shared types and constants for the ru_ram arbiter.
//   arb_state_t  - arbiter FSM states
//   master_t     - identifies the CPU or FPGA master
//   TIMEOUT_DATA - read data returned when a transaction times out
package mem_arb_pkg;

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, DONE} arb_state_t;

  typedef enum logic {M_CPU, M_FPGA} master_t;

  localparam logic [31:0] TIMEOUT_DATA = 32'hDEAD_BEEF;

endpackage

// File: rtl/mem_arbiter_arb_pick.sv
// arb_pick: combinational winner select between the CPU and FPGA masters.
//   req_cpu  - CPU request pending
//   req_fpga - FPGA request pending
//   last     - master granted by the previous completed transaction
//   winner   - selected master (only meaningful when a request is pending)
// FPGA_PRIO=1 gives the FPGA fixed priority; FPGA_PRIO=0 alternates on contention.
module arb_pick
  import mem_arb_pkg::*;
#(
  parameter int unsigned FPGA_PRIO = 1
) (
  input  logic    req_cpu,
  input  logic    req_fpga,
  input  master_t last,
  output master_t winner
);

  always_comb begin
    winner = M_CPU;
    if (req_cpu && req_fpga) begin
      if (FPGA_PRIO != 0) begin
        winner = M_FPGA;
      end else begin
        winner = (last == M_CPU) ? M_FPGA : M_CPU;
      end
    end else if (req_fpga) begin
      winner = M_FPGA;
    end
  end

endmodule

// File: rtl/mem_arbiter.sv
// mem_arbiter: arbitrates single-word CPU and FPGA transactions onto the one ru_ram port.
//   clk, reset           - clock, synchronous active-high reset
//   cpu_*  / fpga_*      - per-master request (level until done), write enable, address,
//                          write data, read data (valid with done) and one-cycle done pulse
//   ram_addr/wdata/wen   - registered transaction towards ru_ram (wen high in ISSUE only)
//   ram_rdata, ram_busy  - response from ru_ram
//   grant_fpga           - high while the FPGA owns the bus
//   err                  - sticky timeout flag
// Optional feature: define MEM_ARB_TIMEOUT_EN to abort a WAIT that lasts TIMEOUT cycles with
// ram_busy high; otherwise WAIT waits indefinitely and err is tied 0.
module mem_arbiter
  import mem_arb_pkg::*;
#(
  parameter int unsigned AW        = 32,
  parameter int unsigned DW        = 32,
  parameter int unsigned FPGA_PRIO = 1,
  parameter int unsigned TIMEOUT   = 16
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          cpu_req,
  input  logic          cpu_wen,
  input  logic [AW-1:0] cpu_addr,
  input  logic [DW-1:0] cpu_wdata,
  output logic [DW-1:0] cpu_rdata,
  output logic          cpu_done,
  input  logic          fpga_req,
  input  logic          fpga_wen,
  input  logic [AW-1:0] fpga_addr,
  input  logic [DW-1:0] fpga_wdata,
  output logic [DW-1:0] fpga_rdata,
  output logic          fpga_done,
  output logic [AW-1:0] ram_addr,
  output logic [DW-1:0] ram_wdata,
  output logic          ram_wen,
  input  logic [DW-1:0] ram_rdata,
  input  logic          ram_busy,
  output logic          grant_fpga,
  output logic          err
);

  arb_state_t    state_q, state_d;
  master_t       pick;
  master_t       owner_q;
  master_t       last_q;
  logic [AW-1:0] addr_q;
  logic [DW-1:0] wdata_q;
  logic          wen_q;
  logic          grant_q;
  logic [DW-1:0] cpu_rdata_q;
  logic [DW-1:0] fpga_rdata_q;
  logic          any_req;
  logic          timeout;

  assign any_req = cpu_req | fpga_req;

  arb_pick #(
    .FPGA_PRIO(FPGA_PRIO)
  ) u_arb_pick (
    .req_cpu (cpu_req),
    .req_fpga(fpga_req),
    .last    (last_q),
    .winner  (pick)
  );

`ifdef MEM_ARB_TIMEOUT_EN
  localparam int unsigned CntW = $clog2(TIMEOUT + 1);

  logic [CntW-1:0] cnt_q;
  logic            err_q;

  // cnt_q holds the number of busy WAIT cycles already elapsed, so the
  // TIMEOUT-th busy WAIT cycle is the one that aborts.
  assign timeout = (state_q == WAIT) && ram_busy && (cnt_q == CntW'(TIMEOUT - 1));

  always_ff @(posedge clk) begin
    if (reset) begin
      cnt_q <= '0;
      err_q <= 1'b0;
    end else begin
      if (state_q != WAIT) begin
        cnt_q <= '0;
      end else if (ram_busy) begin
        cnt_q <= cnt_q + 1'b1;
      end
      if (timeout) begin
        err_q <= 1'b1;
      end
    end
  end

  assign err = err_q;
`else
  logic unused_timeout;
  assign unused_timeout = ^TIMEOUT;
  assign timeout        = 1'b0;
  assign err            = 1'b0;
`endif

  // State register.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    if (any_req) state_d = ISSUE;
      ISSUE:   state_d = WAIT;
      WAIT:    if (!ram_busy || timeout) state_d = DONE;
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Outputs decoded from state.
  always_comb begin
    ram_wen   = (state_q == ISSUE) && wen_q;
    cpu_done  = (state_q == DONE) && (owner_q == M_CPU);
    fpga_done = (state_q == DONE) && (owner_q == M_FPGA);
  end

  // Transaction latch, read data capture and round-robin pointer.
  always_ff @(posedge clk) begin
    if (reset) begin
      owner_q      <= M_CPU;
      last_q       <= M_FPGA;  // CPU wins the first contended grant
      addr_q       <= '0;
      wdata_q      <= '0;
      wen_q        <= 1'b0;
      grant_q      <= 1'b0;
      cpu_rdata_q  <= '0;
      fpga_rdata_q <= '0;
    end else begin
      if (state_q == IDLE && any_req) begin
        owner_q <= pick;
        grant_q <= (pick == M_FPGA);
        if (pick == M_FPGA) begin
          addr_q  <= fpga_addr;
          wdata_q <= fpga_wdata;
          wen_q   <= fpga_wen;
        end else begin
          addr_q  <= cpu_addr;
          wdata_q <= cpu_wdata;
          wen_q   <= cpu_wen;
        end
      end

      if (state_q == WAIT) begin
        if (timeout) begin
          if (owner_q == M_FPGA) fpga_rdata_q <= DW'(TIMEOUT_DATA);
          else                   cpu_rdata_q  <= DW'(TIMEOUT_DATA);
        end else if (!ram_busy && !wen_q) begin
          if (owner_q == M_FPGA) fpga_rdata_q <= ram_rdata;
          else                   cpu_rdata_q  <= ram_rdata;
        end
      end

      if (state_q == DONE) begin
        last_q  <= owner_q;
        grant_q <= 1'b0;
      end
    end
  end

  assign ram_addr   = addr_q;
  assign ram_wdata  = wdata_q;
  assign grant_fpga = grant_q;
  assign cpu_rdata  = cpu_rdata_q;
  assign fpga_rdata = fpga_rdata_q;

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter: one instance with FPGA priority, one round-robin.
module tb_mem_arbiter;

  localparam int unsigned AW = 32;
  localparam int unsigned DW = 32;

  logic          clk = 1'b0;
  logic          reset;
  logic          cpu_req, cpu_wen, fpga_req, fpga_wen;
  logic [AW-1:0] cpu_addr, fpga_addr;
  logic [DW-1:0] cpu_wdata, fpga_wdata, ram_rdata;
  logic          ram_busy;

  logic [DW-1:0] cpu_rdata, fpga_rdata, ram_wdata;
  logic [AW-1:0] ram_addr;
  logic          cpu_done, fpga_done, ram_wen, grant_fpga, err;

  logic [DW-1:0] rr_cpu_rdata, rr_fpga_rdata, rr_ram_wdata;
  logic [AW-1:0] rr_ram_addr;
  logic          rr_cpu_done, rr_fpga_done, rr_ram_wen, rr_grant_fpga, rr_err;

  int            n_checks = 0;
  int            n_fails  = 0;

  int            wen_cycles, addr_bad;
  logic [AW-1:0] wen_addr, first_addr;
  logic [DW-1:0] wen_data;
  logic          grant_seen, other_done;

  always #5 clk = ~clk;

  mem_arbiter #(
    .AW(AW), .DW(DW), .FPGA_PRIO(1), .TIMEOUT(16)
  ) dut (
    .clk(clk), .reset(reset),
    .cpu_req(cpu_req), .cpu_wen(cpu_wen), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
    .cpu_rdata(cpu_rdata), .cpu_done(cpu_done),
    .fpga_req(fpga_req), .fpga_wen(fpga_wen), .fpga_addr(fpga_addr),
    .fpga_wdata(fpga_wdata), .fpga_rdata(fpga_rdata), .fpga_done(fpga_done),
    .ram_addr(ram_addr), .ram_wdata(ram_wdata), .ram_wen(ram_wen), .ram_rdata(ram_rdata),
    .ram_busy(ram_busy), .grant_fpga(grant_fpga), .err(err)
  );

  mem_arbiter #(
    .AW(AW), .DW(DW), .FPGA_PRIO(0), .TIMEOUT(16)
  ) dut_rr (
    .clk(clk), .reset(reset),
    .cpu_req(cpu_req), .cpu_wen(cpu_wen), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
    .cpu_rdata(rr_cpu_rdata), .cpu_done(rr_cpu_done),
    .fpga_req(fpga_req), .fpga_wen(fpga_wen), .fpga_addr(fpga_addr),
    .fpga_wdata(fpga_wdata), .fpga_rdata(rr_fpga_rdata), .fpga_done(rr_fpga_done),
    .ram_addr(rr_ram_addr), .ram_wdata(rr_ram_wdata), .ram_wen(rr_ram_wen),
    .ram_rdata(ram_rdata), .ram_busy(ram_busy), .grant_fpga(rr_grant_fpga), .err(rr_err)
  );

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fails++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Steps until the selected master's done (or limit), recording bus activity on dut.
  task automatic run_txn(input bit for_fpga, input int limit, input int busy_rel,
                         output int cyc);
    logic hit;
    cyc        = 0;
    hit        = 1'b0;
    wen_cycles = 0;
    addr_bad   = 0;
    grant_seen = 1'b0;
    other_done = 1'b0;
    while (!hit && cyc < limit) begin
      step();
      cyc++;
      if (cyc == 1) first_addr = ram_addr;
      else if (ram_addr !== first_addr) addr_bad++;
      if (ram_wen) begin
        wen_cycles++;
        wen_addr = ram_addr;
        wen_data = ram_wdata;
      end
      if (grant_fpga) grant_seen = 1'b1;
      if (for_fpga ? cpu_done : fpga_done) other_done = 1'b1;
      hit = for_fpga ? fpga_done : cpu_done;
      if (cyc == busy_rel) ram_busy = 1'b0;
    end
  endtask

  initial begin
    int cyc;
    int order[3];
    int n_rr;
    int prio_fpga_n, prio_cpu_n, late_done;

    reset      = 1'b1;
    cpu_req    = 1'b0; cpu_wen  = 1'b0; cpu_addr  = '0; cpu_wdata  = '0;
    fpga_req   = 1'b0; fpga_wen = 1'b0; fpga_addr = '0; fpga_wdata = '0;
    ram_rdata  = '0;   ram_busy = 1'b0;
    step();
    step();
    check("rst_ctrl", {cpu_done, fpga_done, ram_wen, grant_fpga, err}, 5'b0);
    check("rst_addr", ram_addr, 32'h0);
    check("rst_rdata", {cpu_rdata, fpga_rdata}, 64'h0);
    reset = 1'b0;

    // CPU read alone.
    cpu_req = 1'b1; cpu_wen = 1'b0; cpu_addr = 32'h10; ram_rdata = 32'h1234_5678;
    run_txn(1'b0, 20, 0, cyc);
    check("cpu_rd_latency", cyc, 3);
    check("cpu_rd_data", cpu_rdata, 32'h1234_5678);
    check("cpu_rd_grant", grant_seen, 1'b0);
    check("cpu_rd_no_wen", wen_cycles, 0);
    check("cpu_rd_addr", first_addr, 32'h10);
    cpu_req = 1'b0;
    step();
    check("cpu_done_pulse", cpu_done, 1'b0);

    // FPGA write alone; a read value sits on ram_rdata and must not be captured.
    fpga_req = 1'b1; fpga_wen = 1'b1; fpga_addr = 32'h4; fpga_wdata = 32'hA5A5_A5A5;
    ram_rdata = 32'h0BAD_0BAD;
    run_txn(1'b1, 20, 0, cyc);
    check("fpga_wr_latency", cyc, 3);
    check("fpga_wr_wen_cycles", wen_cycles, 1);
    check("fpga_wr_addr", wen_addr, 32'h4);
    check("fpga_wr_data", wen_data, 32'hA5A5_A5A5);
    check("fpga_wr_rdata_kept", fpga_rdata, 32'h0);
    check("fpga_wr_grant", grant_seen, 1'b1);
    fpga_req = 1'b0; fpga_wen = 1'b0;
    step();
    check("fpga_grant_cleared", grant_fpga, 1'b0);

    // CPU read with req dropped and inputs changed after the grant.
    cpu_req = 1'b1; cpu_addr = 32'h20; ram_rdata = 32'hCAFE_F00D;
    step();
    cpu_req = 1'b0; cpu_addr = 32'h99;
    run_txn(1'b0, 20, 0, cyc);
    check("drop_req_latency", cyc, 2);
    check("drop_req_addr_held", ram_addr, 32'h20);
    check("drop_req_rdata", cpu_rdata, 32'hCAFE_F00D);
    step();

    // Simultaneous reads, FPGA priority.
    cpu_req = 1'b1; cpu_addr = 32'h30; fpga_req = 1'b1; fpga_addr = 32'h40;
    ram_rdata = 32'h1111_1111;
    run_txn(1'b1, 20, 0, cyc);
    check("prio_fpga_first", cyc, 3);
    check("prio_fpga_addr", first_addr, 32'h40);
    check("prio_cpu_waits", other_done, 1'b0);
    fpga_req = 1'b0;
    ram_rdata = 32'h2222_2222;
    run_txn(1'b0, 20, 0, cyc);
    check("prio_cpu_gap", cyc, 4);
    check("prio_cpu_grant", grant_seen, 1'b0);
    check("prio_fpga_rdata", fpga_rdata, 32'h1111_1111);
    check("prio_cpu_rdata", cpu_rdata, 32'h2222_2222);
    cpu_req = 1'b0;
    step();

    // Both requests held: round-robin alternates, fixed priority starves the CPU.
    reset = 1'b1;
    step();
    reset = 1'b0;
    cpu_req = 1'b1; fpga_req = 1'b1; ram_rdata = 32'h3333_3333;
    order = '{-1, -1, -1};
    n_rr = 0; prio_fpga_n = 0; prio_cpu_n = 0; late_done = 0;
    for (int i = 1; i <= 12; i++) begin
      step();
      if (rr_cpu_done || rr_fpga_done) begin
        if (n_rr < 3) order[n_rr] = rr_fpga_done ? 1 : 0;
        if (n_rr < 3 && i != 4 * n_rr + 3) late_done++;
        n_rr++;
      end
      if (fpga_done) prio_fpga_n++;
      if (cpu_done) prio_cpu_n++;
    end
    check("rr_count", n_rr, 3);
    check("rr_grant0_cpu", order[0], 0);
    check("rr_grant1_fpga", order[1], 1);
    check("rr_grant2_cpu", order[2], 0);
    check("rr_timing", late_done, 0);
    check("prio_starve_fpga", prio_fpga_n, 3);
    check("prio_starve_cpu", prio_cpu_n, 0);
    cpu_req = 1'b0; fpga_req = 1'b0;
    reset = 1'b1;
    step();
    reset = 1'b0;

    // CPU read with ram_busy high for the first 5 WAIT cycles.
    ram_busy = 1'b1;
    cpu_req = 1'b1; cpu_addr = 32'h50; ram_rdata = 32'h55AA_55AA;
    run_txn(1'b0, 30, 7, cyc);
    check("busy_latency", cyc, 8);
    check("busy_addr_stable", addr_bad, 0);
    check("busy_rdata", cpu_rdata, 32'h55AA_55AA);
    cpu_req = 1'b0;
    step();

    // Reset in the middle of WAIT abandons the transaction.
    ram_busy = 1'b1;
    cpu_req = 1'b1; cpu_wen = 1'b1; cpu_addr = 32'h60; cpu_wdata = 32'h6666_6666;
    step();
    step();
    step();
    check("pre_rst_addr", ram_addr, 32'h60);
    reset = 1'b1; cpu_req = 1'b0; cpu_wen = 1'b0;
    step();
    check("mid_rst_ctrl", {cpu_done, fpga_done, ram_wen, grant_fpga, err}, 5'b0);
    check("mid_rst_bus", {ram_addr, ram_wdata}, 64'h0);
    check("mid_rst_rdata", cpu_rdata, 32'h0);
    reset = 1'b0; ram_busy = 1'b0;
    late_done = 0;
    for (int i = 0; i < 5; i++) begin
      step();
      if (cpu_done || fpga_done) late_done++;
    end
    check("mid_rst_no_done", late_done, 0);

`ifdef MEM_ARB_TIMEOUT_EN
    // ram_busy stuck high: abort after TIMEOUT WAIT cycles.
    ram_busy = 1'b1;
    fpga_req = 1'b1; fpga_wen = 1'b0; fpga_addr = 32'h70;
    run_txn(1'b1, 40, 0, cyc);
    check("to_latency", cyc, 18);
    check("to_rdata", fpga_rdata, 32'hDEAD_BEEF);
    check("to_err", err, 1'b1);
    fpga_req = 1'b0; ram_busy = 1'b0;
    step();
    step();
    step();
    check("to_err_sticky", err, 1'b1);
    reset = 1'b1;
    step();
    reset = 1'b0;
    check("to_err_reset", err, 1'b0);
`else
    check("err_tied_low", {err, rr_err}, 2'b0);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fails);
    $finish;
  end

endmodule
